// File: rtl/fir_out_fifo_pkg.sv
// Shared FIR / output-buffer constants, imported by the FIR datapath and its output FIFO.
// Latency: none (constants only). Backpressure: not applicable.
// Keep these in step with the FIR so the buffer width always matches the filter result.
package fir_out_fifo_pkg;

    localparam int FIR_DATA_W     = 12;
    localparam int FIR_COEF_W     = 12;
    localparam int FIR_OUT_W      = 16;
    localparam int FIR_TAPS       = 16;
    localparam int OUT_FIFO_DEPTH = 16;

endpackage

// File: rtl/fir_out_fifo_btn_edge_sync.sv
// Pushbutton conditioner: 2-FF synchronizer plus rising-edge detect, one pulse per press.
// Latency: level sampled at edge N gives a pulse that is consumed at edge N+2.
// Backpressure: none; a held button produces exactly one pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~dly_q;

endmodule

// File: rtl/fir_out_fifo.sv
// FIR output buffer: 16-entry FIFO filled on the filter strobe, drained one sample per button press.
// Latency: pop lands on dato_out 2 edges after the button is sampled; flags/count are registered.
// Backpressure: none upstream; pushes into a full FIFO are dropped (OUT_FIFO_STICKY_OVF_EN adds ovf_o).
module fir_out_fifo
    import fir_out_fifo_pkg::*;
#(
    parameter  int DATA_W = FIR_OUT_W,
    parameter  int DEPTH  = OUT_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              send_i,
    output logic [DATA_W-1:0] dato_out,
    output logic              dato_valid_o,
    output logic              led_full,
    output logic              led_empty,
    output logic [ADDR_W:0]   count_o
`ifdef OUT_FIFO_STICKY_OVF_EN
    ,
    output logic              ovf_o
`endif
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] dout_q;
    logic              dvld_q;
    logic              pop_req;
    logic              do_pop;
    logic              do_push;

    btn_edge_sync u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (send_i),
        .pulse_o (pop_req)
    );

    // A pop frees a slot in the same edge, so a full FIFO still accepts a simultaneous push.
    always_comb begin
        do_pop   = pop_req & ~empty_q;
        do_push  = wr_valid_i & (~full_q | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
        full_d   = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dout_q   <= '0;
            dvld_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            dvld_q   <= do_pop;
            if (do_pop) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
    end

`ifdef OUT_FIFO_STICKY_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_valid_i & full_q & ~do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign dato_out     = dout_q;
    assign dato_valid_o = dvld_q;
    assign led_full     = full_q;
    assign led_empty    = empty_q;
    assign count_o      = count_q;

endmodule
